// File: rtl/pipe_sequencer.sv
// Pipe obstacle handshake sequencer: requests one pipe sweep at a time, spaces sweeps
// by a frame gap, keeps a saturating BCD score and halts on collision. HISCORE_EN adds a high-score register.
module pipe_sequencer #(
  parameter int GAP_FRAMES  = 30,
  parameter int REQ_TIMEOUT = 4,
  parameter int SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic       start,
  input  logic       collision,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       pipefinish,
  input  logic       addscore,
  output logic       updatepipe,
  output logic       playing,
  output logic       gameover,
  output logic       stall,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens
`ifdef HISCORE_EN
  ,
  output logic [3:0] hiscore_ones,
  output logic [3:0] hiscore_tens
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RUN,
    S_REL,
    S_GAP,
    S_OVER
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       frame_hit;
  logic       frame_hit_q;
  logic       start_q;
  logic       add_q;
  logic       frame_tick;
  logic       start_rise;
  logic       add_rise;
  logic [7:0] frame_cnt;
  logic [8:0] frame_cnt_inc;
  logic       in_game;
  logic [6:0] score_val;

  // The last visible pixel of a frame marks one frame tick.
  assign frame_hit     = (x == 10'd639) && (y == 9'd479);
  assign frame_tick    = frame_hit && !frame_hit_q;
  assign start_rise    = start && !start_q;
  assign add_rise      = addscore && !add_q;
  assign frame_cnt_inc = {1'b0, frame_cnt} + 9'd1;
  assign in_game       = (state == S_REQ) || (state == S_RUN) ||
                         (state == S_REL) || (state == S_GAP);
  assign score_val     = 7'(score_tens) * 7'd10 + 7'(score_ones);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_rise) state_next = S_REQ;
      S_REQ:   if (!pipefinish) state_next = S_RUN;
      S_RUN:   if (pipefinish) state_next = S_REL;
      S_REL:   state_next = S_GAP;
      S_GAP:   if (frame_tick && frame_cnt == 8'(GAP_FRAMES - 1)) state_next = S_REQ;
      S_OVER:  if (start_rise) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
    if (collision && in_game) state_next = S_OVER;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      state       <= S_IDLE;
      frame_hit_q <= 1'b0;
      start_q     <= 1'b0;
      add_q       <= 1'b0;
      frame_cnt   <= 8'd0;
      updatepipe  <= 1'b0;
      playing     <= 1'b0;
      gameover    <= 1'b0;
      stall       <= 1'b0;
    end else begin
      state       <= state_next;
      frame_hit_q <= frame_hit;
      start_q     <= start;
      add_q       <= addscore;
      updatepipe  <= (state_next == S_REQ) || (state_next == S_RUN);
      playing     <= (state_next == S_REQ) || (state_next == S_RUN) ||
                     (state_next == S_REL) || (state_next == S_GAP);
      gameover    <= (state_next == S_OVER);

      // One shared frame counter, restarted on every state change.
      if (state_next != state) frame_cnt <= 8'd0;
      else if (frame_tick && frame_cnt != 8'hFF) frame_cnt <= frame_cnt_inc[7:0];

      if (state == S_REQ && state_next == S_REQ && frame_tick &&
          frame_cnt_inc >= 9'(REQ_TIMEOUT))
        stall <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetGame) begin
      score_ones <= 4'd0;
      score_tens <= 4'd0;
    end else if (start_rise && (state == S_IDLE || state == S_OVER)) begin
      score_ones <= 4'd0;
      score_tens <= 4'd0;
    end else if (add_rise && state == S_RUN && score_val < 7'(SCORE_MAX)) begin
      if (score_ones == 4'd9) begin
        score_ones <= 4'd0;
        score_tens <= score_tens + 4'd1;
      end else begin
        score_ones <= score_ones + 4'd1;
      end
    end
  end

`ifdef HISCORE_EN
  logic [6:0] hiscore_val;
  assign hiscore_val = 7'(hiscore_tens) * 7'd10 + 7'(hiscore_ones);

  // Score is frozen in S_OVER, so comparing there equals comparing on entry.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      hiscore_ones <= 4'd0;
      hiscore_tens <= 4'd0;
    end else if (state == S_OVER && score_val > hiscore_val) begin
      hiscore_ones <= score_ones;
      hiscore_tens <= score_tens;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer; define HISCORE_EN to also exercise the high score.
module tb_pipe_sequencer;

  localparam int GAP = 30;

  logic       clk = 1'b0;
  logic       resetGame, start, collision, pipefinish, addscore;
  logic [9:0] x;
  logic [8:0] y;
  logic       updatepipe, playing, gameover, stall;
  logic [3:0] score_ones, score_tens;
`ifdef HISCORE_EN
  logic [3:0] hiscore_ones, hiscore_tens;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_score = 0;

  pipe_sequencer #(.GAP_FRAMES(GAP), .REQ_TIMEOUT(4), .SCORE_MAX(99)) dut (
    .clk        (clk),
    .resetGame  (resetGame),
    .start      (start),
    .collision  (collision),
    .x          (x),
    .y          (y),
    .pipefinish (pipefinish),
    .addscore   (addscore),
    .updatepipe (updatepipe),
    .playing    (playing),
    .gameover   (gameover),
    .stall      (stall),
    .score_ones (score_ones),
    .score_tens (score_tens)
`ifdef HISCORE_EN
    ,
    .hiscore_ones (hiscore_ones),
    .hiscore_tens (hiscore_tens)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_score(input string tag, input int val);
    check({tag, "_tens"}, 32'(score_tens), 32'(val / 10));
    check({tag, "_ones"}, 32'(score_ones), 32'(val % 10));
  endtask

  task automatic frame_pulse();
    x = 10'd639;
    y = 9'd479;
    step();
    x = 10'd0;
    y = 9'd0;
    step();
  endtask

  task automatic wait_upd(input logic v, input string tag);
    int n = 0;
    while (updatepipe !== v && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(updatepipe), 32'(v));
  endtask

  // Called one cycle into S_GAP: the request must reappear exactly on the GAP-th tick.
  task automatic gap_phase(input string tag);
    repeat (GAP - 1) frame_pulse();
    check({tag, "_gap_low"}, 32'(updatepipe), 32'd0);
    frame_pulse();
    check({tag, "_req_again"}, 32'(updatepipe), 32'd1);
  endtask

  // Starts in S_REQ with pipefinish high; runs one scored sweep and its gap.
  task automatic sweep(input int hold, input string tag);
    step();
    pipefinish = 1'b0;
    step();
    addscore = 1'b1;
    repeat (hold) step();
    addscore = 1'b0;
    if (exp_score < 99) exp_score++;
    check_score(tag, exp_score);
    pipefinish = 1'b1;
    wait_upd(1'b0, {tag, "_rel"});
    step();
    gap_phase(tag);
  endtask

  initial begin
    resetGame  = 1'b1;
    start      = 1'b0;
    collision  = 1'b0;
    pipefinish = 1'b1;
    addscore   = 1'b0;
    x          = 10'd0;
    y          = 9'd0;
    step();
    step();
    check("rst_upd", 32'(updatepipe), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_gameover", 32'(gameover), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check_score("rst_score", 0);
    resetGame = 1'b0;
    step();

    collision = 1'b1;
    step();
    check("idle_coll_gameover", 32'(gameover), 32'd0);
    check("idle_coll_playing", 32'(playing), 32'd0);
    collision = 1'b0;

    // Test 1: unscored sweep with a 2-cycle accept and 100-cycle run.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_req_upd", 32'(updatepipe), 32'd1);
    check("t1_req_playing", 32'(playing), 32'd1);
    step();
    pipefinish = 1'b0;
    step();
    check("t1_run_upd", 32'(updatepipe), 32'd1);
    repeat (100) step();
    pipefinish = 1'b1;
    step();
    check("t1_rel_upd", 32'(updatepipe), 32'd0);
    check("t1_rel_playing", 32'(playing), 32'd1);
    step();
    gap_phase("t1");

    // Test 2: long addscore holds, one increment per sweep, BCD carry at 9 -> 10.
    for (int i = 1; i <= 12; i++) sweep(500, $sformatf("t2_s%0d", i));
    check_score("t2_final", 12);

    // Test 3: fill to 99, then one more scored sweep must saturate.
    for (int i = 13; i <= 99; i++) sweep(3, "t3_fill");
    check_score("t3_at99", 99);
    sweep(3, "t3_sat");
    check_score("t3_hold", 99);

    start = 1'b1;
    step();
    start = 1'b0;
    check("play_start_upd", 32'(updatepipe), 32'd1);
    check_score("play_start_ignored", 99);

    // Test 4: collision mid-run, frozen score, restart.
    step();
    pipefinish = 1'b0;
    repeat (10) step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("t4_gameover", 32'(gameover), 32'd1);
    check("t4_upd", 32'(updatepipe), 32'd0);
    check("t4_playing", 32'(playing), 32'd0);
    addscore = 1'b1;
    step();
    addscore = 1'b0;
    step();
    check_score("t4_frozen", 99);
    pipefinish = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_upd", 32'(updatepipe), 32'd1);
    check("t4_restart_gameover", 32'(gameover), 32'd0);
    check_score("t4_restart_score", 0);

    // Score rise and collision together: increment lands, then game over.
    step();
    pipefinish = 1'b0;
    step();
    addscore  = 1'b1;
    collision = 1'b1;
    step();
    addscore  = 1'b0;
    collision = 1'b0;
    check("t4_both_gameover", 32'(gameover), 32'd1);
    check_score("t4_both_score", 1);
    pipefinish = 1'b1;

    // Test 5: request never accepted -> sticky stall, cleared only by reset.
    start = 1'b1;
    step();
    start = 1'b0;
    check_score("t5_restart_score", 0);
    repeat (3) frame_pulse();
    check("t5_stall_3", 32'(stall), 32'd0);
    frame_pulse();
    check("t5_stall_4", 32'(stall), 32'd1);
    check("t5_still_req", 32'(updatepipe), 32'd1);
    pipefinish = 1'b0;
    step();
    step();
    check("t5_stall_sticky", 32'(stall), 32'd1);
    resetGame = 1'b1;
    step();
    resetGame = 1'b0;
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_upd", 32'(updatepipe), 32'd0);
    check("t5_rst_playing", 32'(playing), 32'd0);
    check("t5_rst_gameover", 32'(gameover), 32'd0);
    check_score("t5_rst_score", 0);
    pipefinish = 1'b1;
    step();

`ifdef HISCORE_EN
    // Test 6: game of 7, then game of 3; high score keeps 7.
    check("t6_rst_hi", 32'({hiscore_tens, hiscore_ones}), 32'h00);
    for (int g = 0; g < 2; g++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      exp_score = 0;
      for (int i = 0; i < (g == 0 ? 7 : 3); i++) sweep(3, "t6_sweep");
      step();
      pipefinish = 1'b0;
      step();
      collision = 1'b1;
      step();
      collision = 1'b0;
      step();
      pipefinish = 1'b1;
      check("t6_hi_tens", 32'(hiscore_tens), 32'd0);
      check("t6_hi_ones", 32'(hiscore_ones), 32'd7);
    end
    check_score("t6_last_score", 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
Game-side initiator for the pipe obstacle handshake. It drives updatepipe, tracks pipefinish to launch one pipe sweep at a time, and inserts a programmable frame gap between sweeps. It converts the pipe scorer's level addscore into single BCD score increments and halts the sequence on collision (game over). It sits between the top-level game control (start button, collision detector, VGA scan position) and the pipe renderer.

Parameters:
GAP_FRAMES, 30, frames to wait between the end of one sweep and the next request (1..255)
REQ_TIMEOUT, 4, frames allowed for pipefinish to fall after a request before the stall flag is raised
SCORE_MAX, 99, saturation value of the BCD score (0..99)

Ports:
clk  input  1  system clock
resetGame  input  1  synchronous active-high reset
start  input  1  level; a rising edge starts or restarts a game
collision  input  1  level; bird/pipe overlap
x  input  10  current VGA scan column
y  input  9  current VGA scan row
pipefinish  input  1  pipe renderer idle/done indication
addscore  input  1  level; pipe has passed the bird
updatepipe  output  1  request/hold for one pipe sweep
playing  output  1  high in S_REQ, S_RUN, S_REL, S_GAP
gameover  output  1  high in S_OVER
stall  output  1  sticky; request not accepted within REQ_TIMEOUT frames
score_ones  output  4  BCD ones digit
score_tens  output  4  BCD tens digit

Behaviour:
- All state is synchronous on clk. resetGame has priority over all other inputs and may be asserted in any state: state=S_IDLE, all outputs 0, edge-detector history registers 0.
- frame_tick: 1-cycle pulse on the rising edge of (x==639 && y==479). start_rise and add_rise are 1-cycle rising-edge pulses of start and addscore, with registered previous values.
- S_IDLE: updatepipe=0. On start_rise, clear the score and go to S_REQ.
- S_REQ: updatepipe=1. When pipefinish==0 (request accepted), go to S_RUN. Count frame_ticks while here; when the count reaches REQ_TIMEOUT, set stall=1 (sticky until reset) and remain in S_REQ.
- S_RUN: updatepipe=1. When pipefinish==1 (sweep done), go to S_REL.
- S_REL: updatepipe=0 for exactly 1 cycle, then go to S_GAP.
- S_GAP: updatepipe=0. Count frame_ticks; after GAP_FRAMES ticks, go to S_REQ. The counter clears on entry.
- S_OVER: updatepipe=0, gameover=1, score frozen. On start_rise, clear the score and go to S_REQ.
- collision==1 in S_REQ, S_RUN, S_REL or S_GAP forces S_OVER on the next cycle. This has priority over all other transitions except resetGame. collision is ignored in S_IDLE and S_OVER.
- Score: on add_rise while in S_RUN, increment by 1 in BCD. When ones=9, ones wraps to 0 and tens increments. At SCORE_MAX the score holds. add_rise outside S_RUN is ignored. add_rise and collision in the same cycle: the increment is applied, then the block enters S_OVER.
- start_rise in S_REQ, S_RUN, S_REL or S_GAP is ignored.
- Outputs are registered or decoded from the state register. updatepipe changes 1 cycle after the transition condition.

Optional Feature:
Macro HISCORE_EN.
- Defined: adds output hiscore_ones[3:0] and hiscore_tens[3:0]. On entry to S_OVER, if score > hiscore, then hiscore <= score. resetGame clears hiscore. A start_rise clears the score only, never hiscore.
- Not defined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then pulse start; model the pipe (pipefinish drops 2 cycles after updatepipe=1 and rises 100 cycles later) -> state sequence S_REQ, S_RUN, S_REL; updatepipe low for GAP_FRAMES=30 frame_ticks, then high again.
2. Hold addscore high for 500 cycles during S_RUN, repeated 12 sweeps -> score_tens=1, score_ones=2 (one increment per sweep).
3. Preload 99 by running 99 scored sweeps, then score again -> score holds at 9/9.
4. Assert collision mid S_RUN -> gameover=1 and updatepipe=0 on the next cycle, score frozen; start_rise -> score 0/0 and updatepipe=1 one cycle later.
5. Keep pipefinish=1 after a request for 4 frame_ticks -> stall=1 and stays 1; resetGame -> stall=0, S_IDLE, all outputs 0.
6. HISCORE_EN: games scoring 7, then 3 -> hiscore stays 0/7 after the second game over.
